dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 2048, meaning the number of 32-bit storage words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the number of extra cycles between request acceptance and response (0..15).
REQ-003 The block SHALL have the following ports; one clock, and reset is synchronous and active-low:
  i_clk  in  1  clock, all state updates on rising edge
  i_reset  in  1  synchronous active-low reset
  i_req_valid  in  1  request present
  o_req_ready  out  1  request accepted when high with i_req_valid
  i_req_wren  in  1  1 = store, 0 = load
  i_req_addr  in  32  byte address
  i_req_mask  in  4  access size: 0001 byte, 0011 half, 1111 word
  i_req_wdata  in  32  store data, right-aligned
  o_rsp_valid  out  1  response present
  i_rsp_ready  in  1  response consumed when high with o_rsp_valid
  o_rsp_rdata  out  32  load data, right-aligned, unextended
  o_rsp_err  out  1  access rejected (range or alignment)

Function
REQ-004 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-005 In IDLE, o_req_ready SHALL be 1 and the outputs SHALL be o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
REQ-006 In WAIT and RESP, o_req_ready SHALL be 0.
REQ-007 On acceptance, the block SHALL register addr, wren, mask and wdata, and load the wait counter with WAIT_CYCLES.
REQ-008 On acceptance, the next state SHALL be WAIT if WAIT_CYCLES>0, else RESP.
REQ-009 In WAIT, the counter SHALL decrement each cycle, and the block SHALL move to RESP in the cycle after the counter reaches 1.
REQ-010 Total latency SHALL be exactly WAIT_CYCLES+1 cycles from acceptance edge to o_rsp_valid=1.
REQ-011 The storage access SHALL occur on the edge entering RESP.
REQ-012 A store SHALL write only the byte lanes (mask << addr[1:0]), with data shifted left by 8*addr[1:0].
REQ-013 A load SHALL return the word shifted right by 8*addr[1:0], with bytes outside the mask forced to 0.
REQ-014 A store response SHALL carry o_rsp_rdata=0.
REQ-015 In RESP, o_rsp_valid, o_rsp_rdata and o_rsp_err SHALL hold stable until i_rsp_ready=1, after which the next state SHALL be IDLE.
REQ-016 No new request SHALL be accepted in the same cycle a response completes; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-017 A word index addr[31:2] >= DEPTH_WORDS SHALL yield o_rsp_err=1, with no write and rdata=0.
REQ-018 A mask outside {0001, 0011, 1111} SHALL yield o_rsp_err=1, with no write.
REQ-019 Changes on request inputs while the FSM is not in IDLE SHALL be ignored.

Reset
REQ-020 While i_reset=0 at a clock edge, the FSM SHALL enter IDLE, the counter and captured request SHALL clear, and o_rsp_valid, o_rsp_err and o_rsp_rdata SHALL be 0.
REQ-021 A reset asserted in WAIT or RESP SHALL abort the transaction, and a pending store not yet committed SHALL NOT be written.
REQ-022 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-023 With DMEM_MISALIGN_CHECK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL yield o_rsp_err=1 with no write.
REQ-024 Without DMEM_MISALIGN_CHECK_EN, misaligned accesses SHALL be truncated to the lanes inside the addressed word, and o_rsp_err SHALL depend on range and mask only.

Structure
REQ-025 Package dmem_pkg SHALL hold the FSM state enum, the mask constants MASK_BYTE, MASK_HALF and MASK_WORD, and the lane-shift helper function.
REQ-026 Storage SHALL be the sub-module dmem_array: a synchronous single-port array with 4-bit byte write enables, read data registered, and no reset.

Verification
REQ-027 The bench SHALL cover: WAIT_CYCLES=1, store word 0xDEADBEEF at 0x10 then load word 0x10 -> rsp_valid 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-028 The bench SHALL cover: store byte 0xAB at 0x13 then load word 0x10 -> rdata=0xABADBEEF; then load byte 0x13 -> rdata=0x000000AB.
REQ-029 The bench SHALL cover: load word at address 4*DEPTH_WORDS -> err=1, rdata=0; storage unchanged after a store to the same address.
REQ-030 The bench SHALL cover: with DMEM_MISALIGN_CHECK_EN, load half at 0x11 -> err=1; without the macro, the same access gives err=0 and rdata=byte lanes 1..2 of word 0x10.
REQ-031 The bench SHALL cover: hold i_rsp_ready=0 for 5 cycles in RESP -> outputs stable and o_req_ready=0 throughout; on ready=1, IDLE next cycle.
REQ-032 The bench SHALL cover: assert i_reset=0 during WAIT of a store of 0x12345678 to 0x20 -> outputs 0 next cycle, and a later load of 0x20 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, legal access-size masks and byte-lane helpers.
// No ports; imported by dmem_responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Move right-aligned data up to the byte lane selected by the address offset.
  function automatic logic [31:0] lane_shift(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

  // Expand a 4-bit byte mask into a 32-bit bit mask.
  function automatic logic [31:0] mask_bits(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous single-port RAM with per-byte write enables.
// Latency: read data registered, valid the cycle after en. No backpressure, no reset.
// Ports: clk, en (access strobe), we (byte enables), idx (word index), wdata, rdata.
module dmem_array #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, byte/half/word lanes, range/mask checks.
// Latency: WAIT_CYCLES+1 cycles from accept to o_rsp_valid; one access per WAIT_CYCLES+2 cycles.
// Backpressure: o_req_ready only in IDLE; response held stable until i_rsp_ready.
// Ports: i_clk, i_reset (sync, active-low), i_req_* request channel, o_rsp_* / i_rsp_ready response channel.
// Optional: define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wren,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic        wren_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        rsp_valid_q;
  logic        req_ready_q;

  logic        accept;
  logic        go_resp;
  logic [31:0] acc_addr;
  logic        acc_wren;
  logic [3:0]  acc_mask;
  logic [31:0] acc_wdata;
  logic        range_err;
  logic        mask_err;
  logic        align_err;
  logic        acc_err;
  logic [3:0]  acc_be;
  logic        arr_en;
  logic [3:0]  arr_we;
  logic [31:0] arr_rdata;

  assign accept  = (state == IDLE) && i_req_valid;
  // The array access happens on the edge that enters RESP.
  assign go_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));

  // With zero wait cycles the access is issued straight from the request inputs.
  assign acc_addr  = (state == IDLE) ? i_req_addr  : addr_q;
  assign acc_wren  = (state == IDLE) ? i_req_wren  : wren_q;
  assign acc_mask  = (state == IDLE) ? i_req_mask  : mask_q;
  assign acc_wdata = (state == IDLE) ? i_req_wdata : wdata_q;

  assign range_err = {2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign mask_err  = !((acc_mask == MASK_BYTE) || (acc_mask == MASK_HALF) || (acc_mask == MASK_WORD));
`ifdef DMEM_MISALIGN_CHECK_EN
  assign align_err = ((acc_mask == MASK_HALF) && acc_addr[0]) ||
                     ((acc_mask == MASK_WORD) && (acc_addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif
  assign acc_err   = range_err || mask_err || align_err;

  // Lanes shifted past byte 3 fall off: misaligned accesses stay inside the word.
  assign acc_be = acc_mask << acc_addr[1:0];

  // Gating with i_reset keeps a store aborted by reset from committing.
  assign arr_en = go_resp && i_reset;
  assign arr_we = (arr_en && acc_wren && !acc_err) ? acc_be : 4'b0000;

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (i_clk),
    .en    (arr_en),
    .we    (arr_we),
    .idx   (acc_addr[AW+1:2]),
    .wdata (lane_shift(acc_wdata, acc_addr[1:0])),
    .rdata (arr_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      addr_q      <= 32'd0;
      wren_q      <= 1'b0;
      mask_q      <= 4'd0;
      wdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            addr_q      <= i_req_addr;
            wren_q      <= i_req_wren;
            mask_q      <= i_req_mask;
            wdata_q     <= i_req_wdata;
            cnt         <= 4'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state       <= RESP;
              err_q       <= acc_err;
              rsp_valid_q <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= RESP;
            err_q       <= acc_err;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state       <= IDLE;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          err_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = err_q;
  // Array output is held from the RESP entry edge; shift/mask is applied on the way out.
  assign o_rsp_rdata = ((state == RESP) && !wren_q && !err_q) ?
                       ((arr_rdata >> {addr_q[1:0], 3'b000}) & mask_bits(mask_q)) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wren;
  logic [31:0] req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_wren  (req_wren),
    .i_req_addr  (req_addr),
    .i_req_mask  (req_mask),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // One complete transaction; returns response data, error and accept-to-valid latency.
  task automatic xact(input logic wr, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_wren = wr; req_addr = a; req_mask = m; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    xact(1'b1, 32'h0, 4'b1111, 32'h01020304, r_data, r_err, r_lat);
    xact(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, r_data, r_err, r_lat);
    checks++; if (r_lat !== 2) begin failures++; $display("FAIL store_latency got=%0d exp=2", r_lat); end
    checks++; if (r_err !== 1'b0 || r_data !== 32'd0) begin failures++; $display("FAIL store_rsp got=%b/%h exp=0/0", r_err, r_data); end
    xact(1'b0, 32'h10, 4'b1111, 32'h0, r_data, r_err, r_lat);
    checks++; if (r_lat !== 2) begin failures++; $display("FAIL load_latency got=%0d exp=2", r_lat); end
    checks++; if (r_data !== 32'hDEADBEEF) begin failures++; $display("FAIL load_word got=%h exp=deadbeef", r_data); end
    checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL load_word_err got=%b exp=0", r_err); end
  endtask

  task automatic test_byte();
    xact(1'b1, 32'h13, 4'b0001, 32'h000000AB, r_data, r_err, r_lat);
    xact(1'b0, 32'h10, 4'b1111, 32'h0, r_data, r_err, r_lat);
    checks++; if (r_data !== 32'hABADBEEF) begin failures++; $display("FAIL byte_merge got=%h exp=abadbeef", r_data); end
    xact(1'b0, 32'h13, 4'b0001, 32'h0, r_data, r_err, r_lat);
    checks++; if (r_data !== 32'h000000AB) begin failures++; $display("FAIL load_byte got=%h exp=000000ab", r_data); end
  endtask

  task automatic test_range_mask();
    xact(1'b0, 32'(4 * DEPTH), 4'b1111, 32'h0, r_data, r_err, r_lat);
    checks++; if (r_err !== 1'b1 || r_data !== 32'd0) begin failures++; $display("FAIL range_load got=%b/%h exp=1/0", r_err, r_data); end
    xact(1'b1, 32'(4 * DEPTH), 4'b1111, 32'h55555555, r_data, r_err, r_lat);
    checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL range_store_err got=%b exp=1", r_err); end
    // The out-of-range word aliases index 0 in the array; it must be untouched.
    xact(1'b0, 32'h0, 4'b1111, 32'h0, r_data, r_err, r_lat);
    checks++; if (r_data !== 32'h01020304) begin failures++; $display("FAIL range_no_write got=%h exp=01020304", r_data); end
    xact(1'b1, 32'h10, 4'b0101, 32'h11111111, r_data, r_err, r_lat);
    checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL bad_mask_err got=%b exp=1", r_err); end
    xact(1'b0, 32'h10, 4'b1111, 32'h0, r_data, r_err, r_lat);
    checks++; if (r_data !== 32'hABADBEEF) begin failures++; $display("FAIL bad_mask_no_write got=%h exp=abadbeef", r_data); end
  endtask

  task automatic test_misalign();
    xact(1'b0, 32'h11, 4'b0011, 32'h0, r_data, r_err, r_lat);
`ifdef DMEM_MISALIGN_CHECK_EN
    checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", r_err); end
`else
    checks++; if (r_err !== 1'b0 || r_data !== 32'h0000ADBE) begin failures++; $display("FAIL misalign_half got=%b/%h exp=0/0000adbe", r_err, r_data); end
`endif
  endtask

  task automatic test_hold();
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wren = 1'b0; req_addr = 32'h10; req_mask = 4'b1111;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Requests arriving while busy must be ignored.
    req_valid = 1'b1; req_wren = 1'b1; req_addr = 32'h0; req_mask = 4'b1111; req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hABADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got=v%b d%h e%b r%b exp=v1 dabadbeef e0 r0", i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=v%b r%b exp=v0 r1", rsp_valid, req_ready); end
    xact(1'b0, 32'h0, 4'b1111, 32'h0, r_data, r_err, r_lat);
    checks++; if (r_data !== 32'h01020304) begin failures++; $display("FAIL busy_req_ignored got=%h exp=01020304", r_data); end
  endtask

  task automatic test_reset_abort();
    xact(1'b1, 32'h20, 4'b1111, 32'hCAFEF00D, r_data, r_err, r_lat);
    @(negedge clk);
    req_valid = 1'b1; req_wren = 1'b1; req_addr = 32'h20; req_mask = 4'b1111; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin failures++; $display("FAIL abort_outputs got=v%b d%h e%b exp=0", rsp_valid, rsp_rdata, rsp_err); end
    rst_n = 1'b1;
    xact(1'b0, 32'h20, 4'b1111, 32'h0, r_data, r_err, r_lat);
    checks++; if (r_data !== 32'hCAFEF00D) begin failures++; $display("FAIL abort_no_write got=%h exp=cafef00d", r_data); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wren = 1'b0; req_addr = '0; req_mask = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_range_mask();
    test_misalign();
    test_hold();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
